data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter W, default 32, data width in bits.
REQ-002 Parameter N, default 5, address width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 pX_req  input  1  (X=0,1) access request from requester X; held high until pX_ack.
REQ-006 pX_we  input  1  (X=0,1) 1=write, 0=read; valid while pX_req high.
REQ-007 pX_addr  input  N  (X=0,1) word address.
REQ-008 pX_wdata  input  W  (X=0,1) write data.
REQ-009 pX_ack  output  1  (X=0,1) one-cycle completion pulse.
REQ-010 pX_rdata  output  W  (X=0,1) read data; valid when pX_ack=1 on a read.
REQ-011 mem_read  output  1  MemRead strobe to data_memory.
REQ-012 mem_write  output  1  MemWrite strobe to data_memory.
REQ-013 mem_addr  output  N  address to data_memory.
REQ-014 mem_wdata  output  W  write_data to data_memory.
REQ-015 mem_rdata  input  W  read_data from data_memory; valid during the cycle mem_read is high.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-018 IDLE: if any pX_req is high, the winner's we/addr/wdata and its port ID SHALL be latched, with transition to ACCESS; otherwise stay in IDLE.
REQ-019 ACCESS lasts exactly one cycle: mem_addr/mem_wdata SHALL show the latched values, and mem_read=~we and mem_write=we SHALL be asserted for that cycle only.
REQ-020 In ACCESS, on a read, mem_rdata SHALL be captured into the winner's pX_rdata register; next state RESP.
REQ-021 RESP: the winner's pX_ack SHALL be high for exactly one cycle, then return to IDLE.
REQ-022 Latency: request seen in IDLE at edge t gives the strobe in cycle t+1 and ack in cycle t+2; the next grant is sampled no earlier than t+3 (max one transaction per 3 cycles).
REQ-023 Only one of mem_read/mem_write SHALL be high in any cycle; both SHALL be low outside ACCESS.
REQ-024 Non-winning pX_rdata SHALL hold its previous value; a write transaction SHALL NOT change pX_rdata.
REQ-025 Requester inputs SHALL be ignored outside IDLE; requests dropped after grant SHALL still complete and ack.
REQ-026 The loser of a simultaneous request SHALL remain pending (req held) and be granted at the next IDLE.
REQ-027 mem_addr/mem_wdata SHALL hold their last driven values outside ACCESS.
REQ-028 pX_ack SHALL never be asserted for a port that was not granted.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE; mem_read, mem_write, p0_ack, p1_ack, busy = 0; mem_addr, mem_wdata, p0_rdata, p1_rdata = 0; last-grant pointer = 1 (port 0 wins first tie).
REQ-030 Reset in ACCESS or RESP SHALL abort the transaction with no ack issued; reset dominates all other inputs.

Configuration
REQ-031 Macro DMEM_ARB_RR_EN defined: round-robin arbitration; on a tie the port not granted last wins; the pointer updates on each grant.
REQ-032 DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties; the pointer is not implemented.

Verification
REQ-033 Single read: mem word 3 preloaded 0x0000_00AB; p0 read addr 3 -> mem_read high for 1 cycle at t+1, p0_ack at t+2, p0_rdata=0x0000_00AB.
REQ-034 Write then read: p1 write addr 7 data 0xDEAD_BEEF -> mem_write 1 cycle with mem_addr=7; then p1 read addr 7 -> p1_rdata=0xDEAD_BEEF; p1_rdata unchanged after the write alone.
REQ-035 Tie, RR build: p0 and p1 both request continuously -> grant order p0, p1, p0, p1; acks 3 cycles apart. Non-RR build: p0 every grant while held.
REQ-036 Reset mid-op: assert rst during ACCESS -> next cycle state IDLE, busy=0, no pX_ack, strobes low; first grant after release goes to p0.
REQ-037 Dropped request: p0 deasserts req the cycle after grant -> p0_ack still pulses once; no second transaction.
REQ-038 Assertion throughout all scenarios: mem_read & mem_write never both 1, and each ack is exactly 1 cycle wide.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter in front of a single-ported data memory.
//
// Each requester raises pX_req and holds it until pX_ack. A grant is taken only
// in the idle state. The granted request spends one cycle in the access state,
// where the memory strobes are driven, and one cycle in the response state,
// where the one-cycle ack is issued. At most one transaction completes every
// three cycles.
//
// Configuration:
//   DMEM_ARB_RR_EN  defined   -> round-robin on a tie (the port not granted last wins)
//                   undefined -> fixed priority, port 0 wins every tie
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   pX_req/we/addr/wdata       requester X (X = 0, 1) request, direction, address, data
//   pX_ack, pX_rdata           requester X completion pulse and read-data register
//   mem_read, mem_write        one-cycle strobes to the data memory
//   mem_addr, mem_wdata        latched address and write data to the data memory
//   mem_rdata                  read data from the data memory (valid while mem_read)
//   busy                       high whenever a transaction is in progress
module data_mem_arbiter #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p0_req,
  input  logic         p0_we,
  input  logic [N-1:0] p0_addr,
  input  logic [W-1:0] p0_wdata,
  output logic         p0_ack,
  output logic [W-1:0] p0_rdata,
  input  logic         p1_req,
  input  logic         p1_we,
  input  logic [N-1:0] p1_addr,
  input  logic [W-1:0] p1_wdata,
  output logic         p1_ack,
  output logic [W-1:0] p1_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [N-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e         state_q, state_d;
  logic           load;       // take a grant this cycle
  logic           win;        // winning port id (0 or 1)
  logic           grant_q;    // port id of the transaction in flight
  logic           we_q;
  logic [N-1:0]   addr_q;
  logic [W-1:0]   wdata_q;
  logic [W-1:0]   rdata0_q, rdata1_q;

`ifdef DMEM_ARB_RR_EN
  logic           last_q;     // port granted most recently; reset to 1 so port 0 wins first tie

  always_comb begin
    if (p0_req && p1_req) begin
      win = ~last_q;
    end else begin
      win = p1_req & ~p0_req;
    end
  end
`else
  always_comb begin
    win = ~p0_req;
  end
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (p0_req || p1_req) begin
          state_d = StAccess;
          load    = 1'b1;
        end
      end
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (load) begin
        grant_q <= win;
        we_q    <= win ? p1_we    : p0_we;
        addr_q  <= win ? p1_addr  : p0_addr;
        wdata_q <= win ? p1_wdata : p0_wdata;
`ifdef DMEM_ARB_RR_EN
        last_q  <= win;
`endif
      end
      // Read data is valid only during the access cycle; capture it for the owner.
      if (state_q == StAccess && !we_q) begin
        if (grant_q) begin
          rdata1_q <= mem_rdata;
        end else begin
          rdata0_q <= mem_rdata;
        end
      end
    end
  end

  always_comb begin
    mem_read  = (state_q == StAccess) && !we_q;
    mem_write = (state_q == StAccess) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    p0_ack    = (state_q == StResp) && !grant_q;
    p1_ack    = (state_q == StResp) && grant_q;
    p0_rdata  = rdata0_q;
    p1_rdata  = rdata1_q;
    busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized self-checking bench for data_mem_arbiter. A simple data memory is
// modelled behind the DUT; expected results come from a transaction-level
// reference (reference memory, last-grant pointer, per-port read registers).
module tb_data_mem_arbiter;

  localparam int unsigned W = 32;
  localparam int unsigned N = 5;
  localparam int unsigned Words = 2 ** N;

  logic         clk = 1'b0;
  logic         rst;
  logic         p0_req, p0_we, p1_req, p1_we;
  logic [N-1:0] p0_addr, p1_addr;
  logic [W-1:0] p0_wdata, p1_wdata;
  logic         p0_ack, p1_ack;
  logic [W-1:0] p0_rdata, p1_rdata;
  logic         mem_read, mem_write;
  logic [N-1:0] mem_addr;
  logic [W-1:0] mem_wdata, mem_rdata;
  logic         busy;

  always #5 clk = ~clk;

  data_mem_arbiter #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_ack    (p0_ack),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_ack    (p1_ack),
    .p1_rdata  (p1_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Data memory stand-in; preload port used only during reset.
  logic [W-1:0] tb_mem [Words];
  logic         load_en;
  logic [N-1:0] load_addr;
  logic [W-1:0] load_data;

  always @(posedge clk) begin
    if (load_en) tb_mem[load_addr] <= load_data;
    else if (mem_write) tb_mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = tb_mem[mem_addr];

  // Reference model state.
  logic [W-1:0] ref_mem [Words];
  logic [W-1:0] rd_m [2];
  int           last_m;
  logic         req_v [2];
  logic         we_v [2];
  logic [N-1:0] addr_v [2];
  logic [W-1:0] wdata_v [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive_all();
    p0_req = req_v[0]; p0_we = we_v[0]; p0_addr = addr_v[0]; p0_wdata = wdata_v[0];
    p1_req = req_v[1]; p1_we = we_v[1]; p1_addr = addr_v[1]; p1_wdata = wdata_v[1];
  endtask

  task automatic set_pending(input int p, input logic we, input logic [N-1:0] a,
                             input logic [W-1:0] d);
    req_v[p] = 1'b1; we_v[p] = we; addr_v[p] = a; wdata_v[p] = d;
  endtask

  // Called at a falling edge with the DUT idle and at least one request pending.
  task automatic do_txn();
    int           w;
    logic         t_we;
    logic [N-1:0] t_addr;
    logic [W-1:0] t_wdata;
    drive_all();
    if (req_v[0] && req_v[1]) begin
`ifdef DMEM_ARB_RR_EN
      w = (last_m == 1) ? 0 : 1;
`else
      w = 0;
`endif
    end else begin
      w = req_v[1] ? 1 : 0;
    end
    last_m  = w;
    t_we    = we_v[w];
    t_addr  = addr_v[w];
    t_wdata = wdata_v[w];

    @(negedge clk);  // access cycle
    check("acc_busy", busy, 1);
    check("acc_read", mem_read, !t_we);
    check("acc_write", mem_write, t_we);
    check("acc_addr", mem_addr, t_addr);
    if (t_we) check("acc_wdata", mem_wdata, t_wdata);
    check("acc_acks", {p1_ack, p0_ack}, 0);
    // Winner's inputs are ignored after grant: sometimes drop or scramble them.
    if ($urandom_range(0, 2) == 0) begin
      req_v[w] = 1'b0;
      we_v[w] = 1'($urandom); addr_v[w] = N'($urandom); wdata_v[w] = $urandom;
      drive_all();
    end

    @(negedge clk);  // response cycle
    if (t_we) ref_mem[t_addr] = t_wdata;
    else rd_m[w] = ref_mem[t_addr];
    check("rsp_busy", busy, 1);
    check("rsp_strobes", {mem_read, mem_write}, 0);
    check("rsp_ack_win", (w == 0) ? p0_ack : p1_ack, 1);
    check("rsp_ack_lose", (w == 0) ? p1_ack : p0_ack, 0);
    check("rsp_rdata0", p0_rdata, rd_m[0]);
    check("rsp_rdata1", p1_rdata, rd_m[1]);
    req_v[w] = 1'b0;
    drive_all();

    @(negedge clk);  // back to idle
    check("idle_busy", busy, 0);
    check("idle_acks", {p1_ack, p0_ack}, 0);
    check("idle_strobes", {mem_read, mem_write}, 0);
    check("idle_rdata0", p0_rdata, rd_m[0]);
    check("idle_rdata1", p1_rdata, rd_m[1]);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; wdata_v[p] = '0; rd_m[p] = '0;
    end
    drive_all();
    last_m  = 1;
    rst     = 1'b1;
    load_en = 1'b1;
    for (int i = 0; i < int'(Words); i++) begin
      load_addr  = N'(i);
      load_data  = (i == 3) ? 32'h0000_00AB : $urandom;
      ref_mem[i] = load_data;
      @(negedge clk);
    end
    load_en = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_strobes", {mem_read, mem_write}, 0);
    check("rst_acks", {p1_ack, p0_ack}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata0", p0_rdata, 0);
    check("rst_rdata1", p1_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single read of preloaded word 3.
    set_pending(0, 1'b0, N'(3), '0);
    do_txn();
    check("rd3_value", p0_rdata, 32'h0000_00AB);

    // Write then read back on port 1.
    set_pending(1, 1'b1, N'(7), 32'hDEAD_BEEF);
    do_txn();
    check("wr7_rdata_unchanged", p1_rdata, 0);
    set_pending(1, 1'b0, N'(7), '0);
    do_txn();
    check("rd7_value", p1_rdata, 32'hDEAD_BEEF);

    // Continuous tie: both ports keep requesting.
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_v[p]) set_pending(p, 1'($urandom), N'($urandom), $urandom);
      end
      do_txn();
    end

    // Reset in the middle of an access: no ack, then port 0 wins the first tie.
    set_pending(0, 1'b0, N'(5), '0);
    req_v[1] = 1'b0;
    drive_all();
    @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_acks", {p1_ack, p0_ack}, 0);
    check("mrst_strobes", {mem_read, mem_write}, 0);
    check("mrst_rdata0", p0_rdata, 0);
    check("mrst_addr", mem_addr, 0);
    rd_m[0] = '0; rd_m[1] = '0; last_m = 1;
    set_pending(1, 1'b0, N'(9), '0);
    do_txn();

    // Random traffic with pending losers carried between transactions.
    for (int k = 0; k < 80; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_v[p] && $urandom_range(0, 3) != 0)
          set_pending(p, 1'($urandom), N'($urandom), $urandom);
      end
      if (!req_v[0] && !req_v[1]) begin
        drive_all();
        @(negedge clk);
        check("noreq_busy", busy, 0);
        set_pending(int'($urandom_range(0, 1)), 1'($urandom), N'($urandom), $urandom);
      end
      do_txn();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
